// File: rtl/fir_decim_buf.sv
// Decimator with a first-word-fall-through output FIFO and a sticky overflow flag.
// Defining FIR_DECIM_AVG_EN makes each output the floor mean of DECIM inputs.
module fir_decim_buf #(
  parameter int DECIM = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] data_i,
  input  logic              valid_i,
  output logic signed [7:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [AW:0]       count_o,
  output logic              overflow_o
);

  localparam int          PW       = $clog2(DECIM);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [PW-1:0]     phase_q, phase_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic signed [7:0] mem_q [DEPTH];

  logic              keep;
  logic              pop;
  logic              push;
  logic signed [7:0] push_data;

`ifdef FIR_DECIM_AVG_EN
  localparam int            SW      = 8 + PW;
  localparam logic [PW-1:0] LAST_PH = PW'(DECIM - 1);

  logic signed [SW-1:0] acc_q, acc_d;
  logic signed [SW-1:0] sum;

  // The block sum cannot overflow SW bits, so the shifted result always fits in 8.
  always_comb begin
    sum       = acc_q + SW'(data_i);
    keep      = valid_i && (phase_q == LAST_PH);
    push_data = 8'(sum >>> PW);
    acc_d     = acc_q;
    if (valid_i) begin
      acc_d = (phase_q == '0) ? SW'(data_i) : sum;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  always_comb begin
    keep      = valid_i && (phase_q == '0);
    push_data = data_i;
  end
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pop        = (count_q != '0) && ready_i;
    // A pop in the same cycle frees the slot, so push at full is lossless then.
    push       = keep && ((count_q != FULL_CNT) || pop);
    phase_d    = valid_i ? phase_q + PW'(1) : phase_q;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    overflow_d = overflow_q | (keep & ~push);
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is not reset; stale entries are unreachable because count_q gates the head.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign valid_o    = (count_q != '0);
  assign data_o     = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fir_decim_buf.sv
// Randomised and directed bench for fir_decim_buf against a queue-based reference model.
module tb_fir_decim_buf;

  localparam int DECIM = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] data_i;
  logic              valid_i;
  logic signed [7:0] data_o;
  logic              valid_o;
  logic              ready_i;
  logic [AW:0]       count_o;
  logic              overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  int m_q[$];
  int m_ph  = 0;
  int m_acc = 0;
  int m_ovf = 0;

  fir_decim_buf #(.DECIM(DECIM), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .count_o   (count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    int m;
    m = a % b;
    if (m < 0) m += b;
    return (a - m) / b;
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit v, input int d, input bit rd);
    bit pop_m;
    bit k;
    int kv;
    rst     = r;
    valid_i = v;
    data_i  = 8'(d);
    ready_i = rd;
    k  = 1'b0;
    kv = 0;
    if (r) begin
      m_q.delete();
      m_ph  = 0;
      m_acc = 0;
      m_ovf = 0;
    end else begin
      pop_m = (m_q.size() != 0) && rd;
      if (v) begin
`ifdef FIR_DECIM_AVG_EN
        m_acc = (m_ph == 0) ? d : m_acc + d;
        if (m_ph == DECIM - 1) begin
          k  = 1'b1;
          kv = floor_div(m_acc, DECIM);
        end
`else
        if (m_ph == 0) begin
          k  = 1'b1;
          kv = d;
        end
`endif
        m_ph = (m_ph + 1) % DECIM;
      end
      if (pop_m) void'(m_q.pop_front());
      if (k) begin
        if (m_q.size() < DEPTH) m_q.push_back(kv);
        else m_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
    check("valid_o", valid_o, (m_q.size() != 0) ? 1 : 0);
    check("data_o", data_o, (m_q.size() != 0) ? m_q[0] : 0);
    check("count_o", count_o, m_q.size());
    check("overflow_o", overflow_o, m_ovf);
  endtask

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b0;

    // Reset dominates valid input.
    repeat (4) step(1, 1, 55, 1);

    // Basic decimation, consumer always ready.
    for (int i = 1; i <= 16; i++) step(0, 1, i, 1);
    repeat (2) step(0, 0, 0, 1);

    // Gapped input stream.
    step(1, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, i, 1);
      step(0, 0, 0, 1);
    end

    // Fill to full with no consumer, then overflow, then drain.
    step(1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, i + 1, 0);
    check("fill_count", count_o, DEPTH);
    check("fill_ovf", overflow_o, 1);
    repeat (12) step(0, 0, 0, 1);
    check("drain_valid", valid_o, 0);
    check("drain_ovf", overflow_o, 1);

    // Keep event coinciding with a pop while full.
    step(1, 0, 0, 0);
    for (int i = 0; i < 8 * DECIM; i++) step(0, 1, i - 20, 0);
`ifdef FIR_DECIM_AVG_EN
    for (int i = 0; i < DECIM - 1; i++) step(0, 1, 7, 0);
`endif
    step(0, 1, 99, 1);
    check("full_pp_count", count_o, DEPTH);
    check("full_pp_ovf", overflow_o, 0);
    repeat (10) step(0, 0, 0, 1);

`ifdef FIR_DECIM_AVG_EN
    // Averaging with floor rounding and a mid-block reset.
    step(1, 0, 0, 0);
    step(0, 1, 10, 1); step(0, 1, 11, 1); step(0, 1, 12, 1); step(0, 1, 13, 1);
    check("avg_pos", data_o, 11);
    step(0, 1, -1, 1); step(0, 1, -2, 1); step(0, 1, -2, 1); step(0, 1, -2, 1);
    check("avg_neg", data_o, -2);
    step(0, 1, 100, 1); step(0, 1, 100, 1);
    step(1, 0, 0, 1);
    step(0, 1, 20, 1); step(0, 1, 21, 1); step(0, 1, 22, 1); step(0, 1, 23, 1);
    check("avg_after_rst", data_o, 21);
`endif

    // Random traffic with occasional resets.
    step(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)) - 128,
           ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
